a2bridge_sequencer: RTL and testbench
=====================================

A2BRIDGE_SEQUENCER -- requirements
Module: a2bridge_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of requester channels (1..8).
REQ-002 SHALL have parameter SEL_WIDTH, default 3, bridge register-select width.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, bridge data width.
REQ-004 SHALL have parameter SETUP_CYCLES, default 1, select-to-strobe cycles (>=1).
REQ-005 SHALL have parameter STROBE_CYCLES, default 1, strobe-low cycles (>=1).
REQ-006 SHALL have parameter HOLD_CYCLES, default 1, post-strobe hold cycles (>=1).
REQ-007 SHALL have port clk_logic_i  in  1  sole clock, all logic on its rising edge.
REQ-008 SHALL have port system_reset_i  in  1  reset, synchronous, active-high.
REQ-009 SHALL have port req_valid_i  in  NUM_CH  per-channel request pending.
REQ-010 SHALL have port req_ready_o  out  NUM_CH  one-cycle accept pulse, per channel.
REQ-011 SHALL have port req_write_i  in  NUM_CH  1=write, 0=read.
REQ-012 SHALL have port req_sel_i  in  NUM_CH*SEL_WIDTH  packed register select, channel 0 in LSBs.
REQ-013 SHALL have port req_wdata_i  in  NUM_CH*DATA_WIDTH  packed write data.
REQ-014 SHALL have port rsp_valid_o  out  NUM_CH  one-cycle completion pulse to the owning channel.
REQ-015 SHALL have port rsp_rdata_o  out  DATA_WIDTH  read data, valid with rsp_valid_o.
REQ-016 SHALL have port bridge_sel_o  out  SEL_WIDTH  bridge register select.
REQ-017 SHALL have port bridge_rd_n_o / bridge_wr_n_o  out  1 each  active-low strobes.
REQ-018 SHALL have port bridge_d_i  in  DATA_WIDTH  bridge read data.
REQ-019 SHALL have port bridge_d_o / bridge_d_oe_o  out  DATA_WIDTH / 1  write data, output enable.
REQ-020 SHALL have port idle_data_o / idle_change_o  out  DATA_WIDTH / 1  idle-sampled register 0, change pulse.

Function
REQ-021 SHALL be a state machine with states IDLE, SETUP, STROBE and HOLD; IDLE->SETUP on accept, SETUP->STROBE after SETUP_CYCLES, STROBE->HOLD after STROBE_CYCLES, HOLD->IDLE after HOLD_CYCLES.
REQ-022 SHALL, in IDLE, accept the lowest-index channel with req_valid_i high, pulse its req_ready_o, and latch write, sel and wdata that same cycle.
REQ-023 SHALL drive bridge_sel_o with the latched select from SETUP through HOLD, with the strobe high in SETUP and HOLD.
REQ-024 SHALL drive the read strobe (rd_n) low only in STROBE; SHALL capture bridge_d_i on the edge ending the last STROBE cycle; SHALL pulse rsp_valid_o in the first HOLD cycle.
REQ-025 SHALL, for a write, assert bridge_d_oe_o with bridge_d_o=wdata from SETUP through HOLD, drive wr_n low only in STROBE, and pulse rsp_valid_o in the first HOLD cycle.
REQ-026 SHALL never have rd_n and wr_n low together; bridge_d_oe_o SHALL be 0 in IDLE and during reads.
REQ-027 SHALL give accept-to-rsp_valid latency 1+SETUP_CYCLES+STROBE_CYCLES and a period of 1+SETUP+STROBE+HOLD cycles (4 at defaults); the next accept is in the IDLE cycle after HOLD.
REQ-028 SHALL ignore req_valid_i outside IDLE; a channel deasserting before accept SHALL be dropped silently.

Reset
REQ-029 SHALL, on system_reset_i (including mid-transaction), go to IDLE with bridge_sel_o=0, rd_n=1, wr_n=1, bridge_d_o=0, bridge_d_oe_o=0, req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, idle_data_o=all ones, idle_change_o=0, with no rsp_valid for any aborted transaction.

Configuration
REQ-030 SHALL, with A2BRIDGE_IDLE_SAMPLE_EN defined, drive sel=0 and rd_n=0 in IDLE; after two or more consecutive IDLE cycles it SHALL register bridge_d_i into idle_data_o each cycle and pulse idle_change_o when the value differs.
REQ-031 SHALL, without A2BRIDGE_IDLE_SAMPLE_EN, hold rd_n=1 in IDLE, hold idle_data_o at all ones and hold idle_change_o at 0.

Structure
REQ-032 SHALL take the state enum and default timing constants from package a2bridge_pkg.
REQ-033 SHALL use sub-module a2bridge_arbiter, a fixed-priority one-hot grant with index encode.

Verification
REQ-034 Read, channel 0, sel=2, bridge_d_i=8'h5A -> ready at T0, rd_n low at T2 only, rsp_valid_o[0] and rdata=8'h5A at T3.
REQ-035 Write, channel 1, sel=0, wdata=8'hC3 -> wr_n low at T2, d_oe high T1-T3, d_o=8'hC3, rsp_valid_o[1] at T3.
REQ-036 Channels 0 and 2 valid together -> channel 0 served first, channel 2 accepted at T4.
REQ-037 Reset asserted during STROBE -> next edge: strobes high, d_oe=0, no rsp_valid pulse.
REQ-038 IDLE_SAMPLE_EN, idle bridge_d_i changes FF->FB -> idle_data_o=8'hFB with one idle_change_o pulse.

Source files
------------

// File: rtl/a2bridge_pkg.sv
// Shared types and default timing for the a2bridge sequencer slice.
package a2bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } a2_state_e;

  localparam int unsigned DEF_NUM_CH        = 4;
  localparam int unsigned DEF_SEL_WIDTH     = 3;
  localparam int unsigned DEF_DATA_WIDTH    = 8;
  localparam int unsigned DEF_SETUP_CYCLES  = 1;
  localparam int unsigned DEF_STROBE_CYCLES = 1;
  localparam int unsigned DEF_HOLD_CYCLES   = 1;
  localparam int unsigned CNT_W             = 8;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/a2bridge_if.sv
// Requester, response, bridge and idle-sample signals of the a2bridge sequencer.
interface a2bridge_if
  import a2bridge_pkg::*;
#(
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned SEL_WIDTH  = DEF_SEL_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [NUM_CH-1:0]            req_valid_i;
  logic [NUM_CH-1:0]            req_ready_o;
  logic [NUM_CH-1:0]            req_write_i;
  logic [NUM_CH*SEL_WIDTH-1:0]  req_sel_i;
  logic [NUM_CH*DATA_WIDTH-1:0] req_wdata_i;
  logic [NUM_CH-1:0]            rsp_valid_o;
  logic [DATA_WIDTH-1:0]        rsp_rdata_o;
  logic [SEL_WIDTH-1:0]         bridge_sel_o;
  logic                         bridge_rd_n_o;
  logic                         bridge_wr_n_o;
  logic [DATA_WIDTH-1:0]        bridge_d_i;
  logic [DATA_WIDTH-1:0]        bridge_d_o;
  logic                         bridge_d_oe_o;
  logic [DATA_WIDTH-1:0]        idle_data_o;
  logic                         idle_change_o;

  modport master (
    output req_valid_i, req_write_i, req_sel_i, req_wdata_i, bridge_d_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, bridge_sel_o, bridge_rd_n_o,
    input  bridge_wr_n_o, bridge_d_o, bridge_d_oe_o, idle_data_o, idle_change_o
  );

  modport slave (
    input  req_valid_i, req_write_i, req_sel_i, req_wdata_i, bridge_d_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, bridge_sel_o, bridge_rd_n_o,
    output bridge_wr_n_o, bridge_d_o, bridge_d_oe_o, idle_data_o, idle_change_o
  );
endinterface

// File: rtl/a2bridge_arbiter.sv
// Fixed-priority arbiter: lowest-index request wins; one-hot grant plus encoded index.
module a2bridge_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_any
);
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (req[i] && !grant_any) begin
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
        grant_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/a2bridge_sequencer.sv
// Multi-channel sequencer for a strobed register bridge (IDLE/SETUP/STROBE/HOLD).
// Optional idle sampling of register 0 is enabled by defining A2BRIDGE_IDLE_SAMPLE_EN.
module a2bridge_sequencer
  import a2bridge_pkg::*;
#(
  parameter int unsigned NUM_CH        = DEF_NUM_CH,
  parameter int unsigned SEL_WIDTH     = DEF_SEL_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int unsigned STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input logic       clk_logic_i,
  input logic       system_reset_i,
  a2bridge_if.slave bus
);
  localparam int unsigned IDX_W = idx_width(NUM_CH);

  a2_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] owner_idx;
  logic             op_write;
  logic [NUM_CH-1:0] grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_any;
  int unsigned       phase_len;
  logic              phase_last;
`ifdef A2BRIDGE_IDLE_SAMPLE_EN
  logic              idle_run;
`endif

  a2bridge_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arbiter (
    .req       (bus.req_valid_i),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Accept must pulse in the same IDLE cycle the request is seen, so ready is combinational.
  assign bus.req_ready_o = (state == ST_IDLE && !system_reset_i) ? grant : '0;

  always_comb begin
    phase_len = 1;
    case (state)
      ST_SETUP:  phase_len = SETUP_CYCLES;
      ST_STROBE: phase_len = STROBE_CYCLES;
      ST_HOLD:   phase_len = HOLD_CYCLES;
      default:   phase_len = 1;
    endcase
    phase_last = (cnt == CNT_W'(phase_len - 1));
  end

  always_ff @(posedge clk_logic_i) begin
    if (system_reset_i) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      owner_idx         <= '0;
      op_write          <= 1'b0;
      bus.bridge_sel_o  <= '0;
      bus.bridge_rd_n_o <= 1'b1;
      bus.bridge_wr_n_o <= 1'b1;
      bus.bridge_d_o    <= '0;
      bus.bridge_d_oe_o <= 1'b0;
      bus.rsp_valid_o   <= '0;
      bus.rsp_rdata_o   <= '0;
      bus.idle_data_o   <= '1;
      bus.idle_change_o <= 1'b0;
`ifdef A2BRIDGE_IDLE_SAMPLE_EN
      idle_run          <= 1'b0;
`endif
    end else begin
      bus.rsp_valid_o   <= '0;
      bus.idle_change_o <= 1'b0;
`ifdef A2BRIDGE_IDLE_SAMPLE_EN
      idle_run          <= (state == ST_IDLE);
`endif
      case (state)
        ST_IDLE: begin
`ifdef A2BRIDGE_IDLE_SAMPLE_EN
          // First IDLE cycle only just dropped rd_n, so sampling starts one cycle later.
          if (idle_run) begin
            bus.idle_data_o   <= bus.bridge_d_i;
            bus.idle_change_o <= (bus.bridge_d_i != bus.idle_data_o);
          end
          bus.bridge_rd_n_o <= 1'b0;
          bus.bridge_sel_o  <= '0;
`endif
          if (grant_any) begin
            state             <= ST_SETUP;
            cnt               <= '0;
            owner_idx         <= grant_idx;
            op_write          <= bus.req_write_i[grant_idx];
            bus.bridge_sel_o  <= bus.req_sel_i[int'(grant_idx)*SEL_WIDTH +: SEL_WIDTH];
            bus.bridge_rd_n_o <= 1'b1;
            bus.bridge_d_oe_o <= bus.req_write_i[grant_idx];
            bus.bridge_d_o    <= bus.req_write_i[grant_idx] ?
                                 bus.req_wdata_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
          end
        end
        ST_SETUP: begin
          if (phase_last) begin
            state <= ST_STROBE;
            cnt   <= '0;
            if (op_write) bus.bridge_wr_n_o <= 1'b0;
            else          bus.bridge_rd_n_o <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STROBE: begin
          if (phase_last) begin
            state             <= ST_HOLD;
            cnt               <= '0;
            bus.bridge_rd_n_o <= 1'b1;
            bus.bridge_wr_n_o <= 1'b1;
            bus.rsp_valid_o   <= NUM_CH'(1) << owner_idx;
            if (!op_write) bus.rsp_rdata_o <= bus.bridge_d_i;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (phase_last) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            bus.bridge_sel_o  <= '0;
            bus.bridge_d_oe_o <= 1'b0;
            bus.bridge_d_o    <= '0;
`ifdef A2BRIDGE_IDLE_SAMPLE_EN
            bus.bridge_rd_n_o <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_a2bridge_sequencer.sv
// Directed self-checking bench for a2bridge_sequencer at default timing.
module tb_a2bridge_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned failures = 0;

`ifdef A2BRIDGE_IDLE_SAMPLE_EN
  localparam logic RD_IDLE = 1'b0;
`else
  localparam logic RD_IDLE = 1'b1;
`endif

  always #5 clk = ~clk;

  a2bridge_if #(.NUM_CH(4), .SEL_WIDTH(3), .DATA_WIDTH(8)) bus ();

  a2bridge_sequencer #(
    .NUM_CH(4), .SEL_WIDTH(3), .DATA_WIDTH(8),
    .SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)
  ) dut (
    .clk_logic_i    (clk),
    .system_reset_i (rst),
    .bus            (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid_i = 4'b0001;
    bus.req_write_i = '0;
    bus.req_sel_i   = '0;
    bus.req_wdata_i = '0;
    bus.bridge_d_i  = 8'h00;

    // reset state, with a request pending that must not be accepted
    idle_cycles(2);
    #1;
    check_eq("rst_ready",   bus.req_ready_o, 4'b0000);
    check_eq("rst_rd_n",    bus.bridge_rd_n_o, 1'b1);
    check_eq("rst_wr_n",    bus.bridge_wr_n_o, 1'b1);
    check_eq("rst_oe",      bus.bridge_d_oe_o, 1'b0);
    check_eq("rst_d_o",     bus.bridge_d_o, 8'h00);
    check_eq("rst_sel",     bus.bridge_sel_o, 3'd0);
    check_eq("rst_rsp",     bus.rsp_valid_o, 4'b0000);
    check_eq("rst_rdata",   bus.rsp_rdata_o, 8'h00);
    check_eq("rst_idata",   bus.idle_data_o, 8'hFF);
    check_eq("rst_ichange", bus.idle_change_o, 1'b0);
    bus.req_valid_i = '0;
    rst = 1'b0;
    idle_cycles(3);

    // read, channel 0, sel 2, data 5A
    bus.req_sel_i[2:0] = 3'd2;
    bus.bridge_d_i  = 8'h5A;
    bus.req_valid_i = 4'b0001;
    #1;
    check_eq("rd_t0_ready", bus.req_ready_o, 4'b0001);
    check_eq("rd_t0_rd_n",  bus.bridge_rd_n_o, RD_IDLE);
    @(negedge clk);
    check_eq("rd_t1_ready", bus.req_ready_o, 4'b0000);
    check_eq("rd_t1_sel",   bus.bridge_sel_o, 3'd2);
    check_eq("rd_t1_rd_n",  bus.bridge_rd_n_o, 1'b1);
    check_eq("rd_t1_oe",    bus.bridge_d_oe_o, 1'b0);
    bus.req_valid_i = '0;
    bus.bridge_d_i  = 8'h11;
    @(negedge clk);
    check_eq("rd_t2_rd_n",  bus.bridge_rd_n_o, 1'b0);
    check_eq("rd_t2_wr_n",  bus.bridge_wr_n_o, 1'b1);
    check_eq("rd_t2_rsp",   bus.rsp_valid_o, 4'b0000);
    bus.bridge_d_i  = 8'h5A;
    @(negedge clk);
    check_eq("rd_t3_rd_n",  bus.bridge_rd_n_o, 1'b1);
    check_eq("rd_t3_rsp",   bus.rsp_valid_o, 4'b0001);
    check_eq("rd_t3_rdata", bus.rsp_rdata_o, 8'h5A);
    check_eq("rd_t3_sel",   bus.bridge_sel_o, 3'd2);
    bus.bridge_d_i  = 8'h00;
    @(negedge clk);
    check_eq("rd_t4_rsp",   bus.rsp_valid_o, 4'b0000);
    check_eq("rd_t4_sel",   bus.bridge_sel_o, 3'd0);
    check_eq("rd_t4_rdata", bus.rsp_rdata_o, 8'h5A);
    idle_cycles(2);

    // write, channel 1, sel 0, data C3 (channel 0 holds decoy sel/data)
    bus.req_sel_i   = 12'o0007;
    bus.req_wdata_i = 32'h0000_C33C;
    bus.req_write_i = 4'b0010;
    bus.req_valid_i = 4'b0010;
    #1;
    check_eq("wr_t0_ready", bus.req_ready_o, 4'b0010);
    check_eq("wr_t0_oe",    bus.bridge_d_oe_o, 1'b0);
    @(negedge clk);
    check_eq("wr_t1_oe",    bus.bridge_d_oe_o, 1'b1);
    check_eq("wr_t1_d_o",   bus.bridge_d_o, 8'hC3);
    check_eq("wr_t1_sel",   bus.bridge_sel_o, 3'd0);
    check_eq("wr_t1_wr_n",  bus.bridge_wr_n_o, 1'b1);
    bus.req_valid_i = '0;
    @(negedge clk);
    check_eq("wr_t2_wr_n",  bus.bridge_wr_n_o, 1'b0);
    check_eq("wr_t2_rd_n",  bus.bridge_rd_n_o, 1'b1);
    check_eq("wr_t2_oe",    bus.bridge_d_oe_o, 1'b1);
    @(negedge clk);
    check_eq("wr_t3_wr_n",  bus.bridge_wr_n_o, 1'b1);
    check_eq("wr_t3_oe",    bus.bridge_d_oe_o, 1'b1);
    check_eq("wr_t3_d_o",   bus.bridge_d_o, 8'hC3);
    check_eq("wr_t3_rsp",   bus.rsp_valid_o, 4'b0010);
    @(negedge clk);
    check_eq("wr_t4_oe",    bus.bridge_d_oe_o, 1'b0);
    check_eq("wr_t4_rsp",   bus.rsp_valid_o, 4'b0000);
    idle_cycles(2);

    // channels 0 and 2 together: 0 first, 2 accepted at T4
    bus.req_write_i = '0;
    bus.req_sel_i   = 12'o0501;
    bus.req_valid_i = 4'b0101;
    #1;
    check_eq("arb_t0_ready", bus.req_ready_o, 4'b0001);
    @(negedge clk);
    check_eq("arb_t1_ready", bus.req_ready_o, 4'b0000);
    check_eq("arb_t1_sel",   bus.bridge_sel_o, 3'd1);
    bus.req_valid_i = 4'b0100;
    @(negedge clk);
    check_eq("arb_t2_ready", bus.req_ready_o, 4'b0000);
    @(negedge clk);
    check_eq("arb_t3_ready", bus.req_ready_o, 4'b0000);
    check_eq("arb_t3_rsp",   bus.rsp_valid_o, 4'b0001);
    @(negedge clk);
    #1;
    check_eq("arb_t4_ready", bus.req_ready_o, 4'b0100);
    @(negedge clk);
    check_eq("arb_t5_sel",   bus.bridge_sel_o, 3'd5);
    bus.req_valid_i = '0;
    @(negedge clk);
    check_eq("arb_t6_rd_n",  bus.bridge_rd_n_o, 1'b0);
    @(negedge clk);
    check_eq("arb_t7_rsp",   bus.rsp_valid_o, 4'b0100);
    idle_cycles(2);

    // reset during the STROBE of a write on channel 3
    bus.req_write_i = 4'b1000;
    bus.req_wdata_i = 32'hA500_0000;
    bus.req_valid_i = 4'b1000;
    #1;
    check_eq("rst_mid_t0_ready", bus.req_ready_o, 4'b1000);
    @(negedge clk);
    check_eq("rst_mid_t1_oe", bus.bridge_d_oe_o, 1'b1);
    bus.req_valid_i = '0;
    @(negedge clk);
    check_eq("rst_mid_t2_wr_n", bus.bridge_wr_n_o, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_t3_wr_n", bus.bridge_wr_n_o, 1'b1);
    check_eq("rst_mid_t3_rd_n", bus.bridge_rd_n_o, 1'b1);
    check_eq("rst_mid_t3_oe",   bus.bridge_d_oe_o, 1'b0);
    check_eq("rst_mid_t3_d_o",  bus.bridge_d_o, 8'h00);
    check_eq("rst_mid_t3_sel",  bus.bridge_sel_o, 3'd0);
    check_eq("rst_mid_t3_rsp",  bus.rsp_valid_o, 4'b0000);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_t4_rsp",   bus.rsp_valid_o, 4'b0000);
    check_eq("rst_mid_t4_ready", bus.req_ready_o, 4'b0000);
    @(negedge clk);
    check_eq("rst_mid_t5_rsp",   bus.rsp_valid_o, 4'b0000);

    // idle sampling of register 0: FF then FB
    bus.bridge_d_i = 8'hFF;
    idle_cycles(3);
    check_eq("idle_ff_data",   bus.idle_data_o, 8'hFF);
    check_eq("idle_ff_change", bus.idle_change_o, 1'b0);
    check_eq("idle_rd_n",      bus.bridge_rd_n_o, RD_IDLE);
    bus.bridge_d_i = 8'hFB;
    @(negedge clk);
`ifdef A2BRIDGE_IDLE_SAMPLE_EN
    check_eq("idle_fb_data",   bus.idle_data_o, 8'hFB);
    check_eq("idle_fb_change", bus.idle_change_o, 1'b1);
    @(negedge clk);
    check_eq("idle_fb_data2",  bus.idle_data_o, 8'hFB);
    check_eq("idle_fb_change2", bus.idle_change_o, 1'b0);
`else
    check_eq("idle_fb_data",   bus.idle_data_o, 8'hFF);
    check_eq("idle_fb_change", bus.idle_change_o, 1'b0);
    @(negedge clk);
    check_eq("idle_fb_change2", bus.idle_change_o, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
